vram_scan_arbiter: RTL and testbench
====================================

// Module: vram_scan_arbiter
// PURPOSE
//  Shares one single-port synchronous pixel RAM between VGA scan-out and a pixel writer.
//  - Scan-out has absolute priority while DISP_EN=1.
//  - Writer requests are buffered in a FIFO and drained only during blanking.
//  - Sits between the position comparator (DISP_EN/POS_X/POS_Y) and the top-level PIXEL_DATA input.
// PARAMETERS
//  H_RES       640  visible pixels per line; address = POS_Y*H_RES+POS_X
//  V_RES       480  visible lines
//  ADDR_W      19   RAM address width
//  DATA_W      8    pixel width (RRRGGGBB)
//  FIFO_DEPTH  8    write FIFO entries, power of 2, >=2
// PORTS
//  PIX_CLK      in   1       pixel clock, all logic rising-edge
//  RST_IN       in   1       asynchronous reset, active-low
//  DISP_EN      in   1       active-video flag, aligned with POS_X/POS_Y
//  POS_X        in   12      visible column
//  POS_Y        in   12      visible row
//  WR_VALID     in   1       writer request valid
//  WR_READY     out  1       FIFO can accept (count<FIFO_DEPTH)
//  WR_ADDR      in   ADDR_W  writer target address
//  WR_DATA      in   DATA_W  writer pixel
//  MEM_ADDR     out  ADDR_W  RAM address (registered)
//  MEM_WE       out  1       RAM write enable (registered)
//  MEM_WDATA    out  DATA_W  RAM write data (registered)
//  MEM_RDATA    in   DATA_W  RAM read data, valid 1 cycle after MEM_ADDR
//  PIXEL_DATA   out  DATA_W  pixel to colour outputs; 0 when PIXEL_VALID=0
//  PIXEL_VALID  out  1       DISP_EN delayed to match PIXEL_DATA
//  FIFO_LEVEL   out  log2(FIFO_DEPTH)+1  current FIFO occupancy
// BEHAVIOUR
//  Reset (RST_IN=0, async): MEM_ADDR=0, MEM_WE=0, MEM_WDATA=0, PIXEL_DATA=0, PIXEL_VALID=0,
//   FIFO_LEVEL=0, WR_READY=0 while asserted, FSM=IDLE, delay pipes cleared.
//  Reset mid-operation: FIFO flushed, queued writes lost.
//  WR_READY=1 from the first edge after release.
//  FSM, evaluated each PIX_CLK edge, in priority order:
//   - DISP_EN=1 -> SCAN: MEM_ADDR<=POS_Y*H_RES+POS_X (truncated to ADDR_W), MEM_WE<=0.
//   - DISP_EN=0 and FIFO non-empty -> DRAIN: pop head; MEM_ADDR<=entry addr, MEM_WDATA<=entry data, MEM_WE<=1.
//   - otherwise -> IDLE: MEM_WE<=0, MEM_ADDR holds.
//  A write never issues in a cycle where DISP_EN=1; blanking-edge switch takes effect the same cycle.
//  Out-of-range position (POS_X>=H_RES or POS_Y>=V_RES) while DISP_EN=1:
//   - read suppressed (MEM_WE=0, MEM_ADDR holds);
//   - that pixel's PIXEL_DATA=0, PIXEL_VALID still follows DISP_EN.
//  Read latency: POS sampled at edge t -> MEM_ADDR at t+1 -> MEM_RDATA captured at t+2 -> PIXEL_DATA
//   registered at t+3. PIXEL_VALID = DISP_EN delayed 3 edges. PIXEL_DATA=0 whenever PIXEL_VALID=0.
//  Write FIFO:
//   - push on WR_VALID&WR_READY; WR_READY derived from registered count.
//   - push+pop same edge: count unchanged, legal when full (READY low, so no push) and when empty
//     (no pop).
//   - FIFO order preserved; write-to-write same address: last write wins.
//   - pointers wrap modulo FIFO_DEPTH; FIFO_LEVEL saturates at FIFO_DEPTH, never exceeds it.
//  Write vs scan same address: scan returns RAM contents at read time; writes are blanking-only, so
//   there is no intra-cycle hazard.
// CONFIGURATION
//  VRAM_ARB_STALL_CNT_EN defined:
//   - adds output WR_STALL_CNT [15:0]: counts cycles with WR_VALID=1 & WR_READY=0;
//   - saturates at 16'hFFFF; cleared by reset only.
//  Not defined: port and counter absent; no other behaviour change.
// TESTING
//  1 Reset: hold RST_IN=0 with WR_VALID=1 -> all outputs 0, no pushes, FIFO_LEVEL=0.
//  2 Scan: DISP_EN=1, POS_Y=2, POS_X=5 -> MEM_ADDR=1285 at t+1; RAM model word 8'hA5 -> PIXEL_DATA=A5,
//    PIXEL_VALID=1 at t+3.
//  3 Priority: push 3 writes during DISP_EN=1 -> MEM_WE stays 0, FIFO_LEVEL=3; on DISP_EN=0 three
//    consecutive MEM_WE=1 cycles in push order, FIFO_LEVEL 3->0.
//  4 Full: push 8 writes during active video -> WR_READY=0 after 8th; a 9th held WR_VALID is accepted
//    the cycle after the first blanking pop.
//  5 Boundary: POS_X=640 with DISP_EN=1 -> no MEM_ADDR change, PIXEL_DATA=0, PIXEL_VALID=1 at t+3.
//  6 Mid-reset: assert RST_IN=0 with FIFO_LEVEL=5 in blanking -> MEM_WE=0 immediately; after release
//    FIFO_LEVEL=0 and no stale writes issue.

Source files
------------

// File: rtl/vram_scan_arbiter_if.sv
// vram_scan_arbiter_if: pixel-writer request handshake into the VRAM arbiter
// Ports (per modport):
//   master (writer)  : drives valid, addr, data; samples ready
//   slave  (arbiter) : samples valid, addr, data; drives ready
// A request transfers on a rising clock edge where valid and ready are both high.
interface vram_scan_arbiter_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 8
);
  logic valid;
  logic ready;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  modport master (output valid, addr, data, input ready);
  modport slave (input valid, addr, data, output ready);
endinterface

// File: rtl/vram_scan_arbiter.sv
// vram_scan_arbiter: shares one single-port sync pixel RAM between VGA scan-out and a buffered writer
// Ports:
//   pix_clk      pixel clock, rising edge
//   rst_in       asynchronous reset, active low
//   disp_en      active-video flag, aligned with pos_x/pos_y
//   pos_x/pos_y  visible column/row
//   wr           writer handshake (valid/ready/addr/data), queued in a write FIFO
//   mem_addr/mem_we/mem_wdata  registered RAM controls
//   mem_rdata    RAM read data, valid one cycle after mem_addr
//   pixel_data   scanned pixel, zero when pixel_valid is low
//   pixel_valid  disp_en delayed three cycles
//   fifo_level   write FIFO occupancy
//   wr_stall_cnt (only with VRAM_ARB_STALL_CNT_EN) saturating count of cycles valid & !ready
// Configuration macro: VRAM_ARB_STALL_CNT_EN adds the stall counter; undefined leaves it out.
module vram_scan_arbiter #(
  parameter int H_RES = 640,
  parameter int V_RES = 480,
  parameter int ADDR_W = 19,
  parameter int DATA_W = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic pix_clk,
  input  logic rst_in,
  input  logic disp_en,
  input  logic [11:0] pos_x,
  input  logic [11:0] pos_y,
  vram_scan_arbiter_if.slave wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] pixel_data,
  output logic pixel_valid,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
`ifdef VRAM_ARB_STALL_CNT_EN
  ,
  output logic [15:0] wr_stall_cnt
`endif
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;
  state_t state;
  logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [LVL_W-1:0] count, count_nxt;
  logic ready, push, pop, in_range, en_d1, en_d2, rd_ok;
  logic [ADDR_W-1:0] scan_addr;
  assign wr.ready = ready;
  assign fifo_level = count;
  always_comb begin
    in_range = pos_x < 12'(H_RES) && pos_y < 12'(V_RES);
    scan_addr = ADDR_W'(32'(pos_y) * 32'(H_RES) + 32'(pos_x));
    push = wr.valid && ready;
    pop = !disp_en && count != '0;
    count_nxt = count + LVL_W'(push) - LVL_W'(pop);
  end
  always_ff @(posedge pix_clk)
    if (push) begin
      fifo_addr[wr_ptr] <= wr.addr;
      fifo_data[wr_ptr] <= wr.data;
    end
  // state==SCAN marks a read issued this cycle, so rd_ok lines up with the RAM data one cycle later
  always_ff @(posedge pix_clk or negedge rst_in)
    if (!rst_in) begin
      state <= IDLE;
      mem_addr <= '0;
      mem_we <= 1'b0;
      mem_wdata <= '0;
      pixel_data <= '0;
      pixel_valid <= 1'b0;
      en_d1 <= 1'b0;
      en_d2 <= 1'b0;
      rd_ok <= 1'b0;
      count <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      ready <= 1'b0;
    end else begin
      count <= count_nxt;
      ready <= count_nxt != LVL_W'(FIFO_DEPTH);
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      en_d1 <= disp_en;
      en_d2 <= en_d1;
      pixel_valid <= en_d2;
      rd_ok <= state == SCAN;
      pixel_data <= rd_ok ? mem_rdata : '0;
      if (disp_en) begin
        state <= in_range ? SCAN : IDLE;
        mem_we <= 1'b0;
        if (in_range) mem_addr <= scan_addr;
      end else if (pop) begin
        state <= DRAIN;
        mem_we <= 1'b1;
        mem_addr <= fifo_addr[rd_ptr];
        mem_wdata <= fifo_data[rd_ptr];
      end else begin
        state <= IDLE;
        mem_we <= 1'b0;
      end
    end
`ifdef VRAM_ARB_STALL_CNT_EN
  always_ff @(posedge pix_clk or negedge rst_in)
    if (!rst_in) wr_stall_cnt <= '0;
    else if (wr.valid && !ready && wr_stall_cnt != 16'hFFFF) wr_stall_cnt <= wr_stall_cnt + 16'd1;
`else
`endif
endmodule

// File: tb/tb_vram_scan_arbiter.sv
// tb_vram_scan_arbiter: self-checking bench for vram_scan_arbiter with a queue-based reference model
module tb_vram_scan_arbiter;
  localparam int AW = 19;
  localparam int DW = 8;
  localparam int DEPTH = 8;
  typedef struct {
    logic en;
    logic [11:0] x;
    logic [11:0] y;
    logic [AW-1:0] addr;
    logic [DW-1:0] pix;
    logic pv;
  } vec_t;
  logic pix_clk = 1'b0;
  logic rst_in = 1'b1;
  logic disp_en = 1'b0;
  logic [11:0] pos_x = '0;
  logic [11:0] pos_y = '0;
  logic [AW-1:0] mem_addr;
  logic mem_we;
  logic [DW-1:0] mem_wdata, mem_rdata, pixel_data;
  logic pixel_valid;
  logic [3:0] fifo_level;
`ifdef VRAM_ARB_STALL_CNT_EN
  logic [15:0] wr_stall_cnt;
`endif
  vram_scan_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) wr ();
  vram_scan_arbiter dut (
    .pix_clk(pix_clk), .rst_in(rst_in), .disp_en(disp_en), .pos_x(pos_x), .pos_y(pos_y),
    .wr(wr), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .pixel_data(pixel_data), .pixel_valid(pixel_valid), .fifo_level(fifo_level)
`ifdef VRAM_ARB_STALL_CNT_EN
    , .wr_stall_cnt(wr_stall_cnt)
`endif
  );
  always #5 pix_clk = ~pix_clk;
  function automatic logic [DW-1:0] init_val(int a);
    return (a == 1285) ? 8'hA5 : 8'(a);
  endfunction
  logic [DW-1:0] ram [0:(1<<AW)-1];
  initial begin
    for (int i = 0; i < (1 << AW); i++) ram[i] = init_val(i);
    forever begin
      @(posedge pix_clk);
      mem_rdata <= ram[mem_addr];
      if (mem_we) ram[mem_addr] = mem_wdata;
    end
  end
  int n_cmp = 0;
  int n_bad = 0;
  logic [DW-1:0] ref_ram [0:(1<<AW)-1];
  logic [AW-1:0] qa [$];
  logic [DW-1:0] qd [$];
  logic m_ready, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic pv [3];
  logic [DW-1:0] pd [3];
  logic [15:0] m_stall;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask
  task automatic model_reset();
    qa.delete();
    qd.delete();
    m_ready = 0;
    m_we = 0;
    m_addr = '0;
    m_wdata = '0;
    m_stall = '0;
    for (int i = 0; i < 3; i++) begin
      pv[i] = 0;
      pd[i] = '0;
    end
  endtask
  task automatic model_step();
    logic push, pop, inr;
    logic [AW-1:0] lin;
    if (m_we) ref_ram[m_addr] = m_wdata;
    if (wr.valid && !m_ready && m_stall != 16'hFFFF) m_stall++;
    push = wr.valid && m_ready;
    pop = !disp_en && qa.size() > 0;
    inr = pos_x < 640 && pos_y < 480;
    lin = AW'(pos_y * 640 + pos_x);
    pv[2] = pv[1];
    pv[1] = pv[0];
    pv[0] = disp_en;
    pd[2] = pd[1];
    pd[1] = pd[0];
    pd[0] = (disp_en && inr) ? ref_ram[lin] : '0;
    m_we = pop;
    if (disp_en) begin
      if (inr) m_addr = lin;
    end else if (pop) begin
      m_addr = qa.pop_front();
      m_wdata = qd.pop_front();
    end
    if (push) begin
      qa.push_back(wr.addr);
      qd.push_back(wr.data);
    end
    m_ready = qa.size() < DEPTH;
  endtask
  task automatic cmp_all();
    chk("mem_we", mem_we, m_we);
    chk("mem_addr", mem_addr, m_addr);
    chk("mem_wdata", mem_wdata, m_wdata);
    chk("fifo_level", fifo_level, qa.size());
    chk("wr_ready", wr.ready, m_ready);
    chk("pixel_valid", pixel_valid, pv[2]);
    chk("pixel_data", pixel_data, pd[2]);
`ifdef VRAM_ARB_STALL_CNT_EN
    chk("wr_stall_cnt", wr_stall_cnt, m_stall);
`endif
  endtask
  task automatic step();
    model_step();
    @(posedge pix_clk);
    #1;
    cmp_all();
  endtask
  task automatic chk_zero(string tag);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_we"}, mem_we, 0);
    chk({tag, "_wdata"}, mem_wdata, 0);
    chk({tag, "_pix"}, pixel_data, 0);
    chk({tag, "_pv"}, pixel_valid, 0);
    chk({tag, "_level"}, fifo_level, 0);
    chk({tag, "_ready"}, wr.ready, 0);
  endtask
  task automatic set_wr(logic v, logic [AW-1:0] a, logic [DW-1:0] d);
    wr.valid = v;
    wr.addr = a;
    wr.data = d;
  endtask
  vec_t vt [9];
  int alen, blen, bx, by;
  initial begin
    vt[0] = '{1'b1, 12'd5, 12'd2, 19'd1285, 8'hA5, 1'b1};
    vt[1] = '{1'b1, 12'd640, 12'd2, 19'd1285, 8'h00, 1'b1};
    vt[2] = '{1'b1, 12'd0, 12'd0, 19'd0, 8'h00, 1'b1};
    vt[3] = '{1'b1, 12'd639, 12'd479, 19'd307199, 8'hFF, 1'b1};
    vt[4] = '{1'b1, 12'd0, 12'd480, 19'd307199, 8'h00, 1'b1};
    vt[5] = '{1'b1, 12'd100, 12'd10, 19'd6500, 8'h64, 1'b1};
    vt[6] = '{1'b1, 12'd4095, 12'd4095, 19'd6500, 8'h00, 1'b1};
    vt[7] = '{1'b1, 12'd639, 12'd0, 19'd639, 8'h7F, 1'b1};
    vt[8] = '{1'b0, 12'd3, 12'd3, 19'd639, 8'h00, 1'b0};
    for (int i = 0; i < (1 << AW); i++) ref_ram[i] = init_val(i);
    model_reset();
    set_wr(1'b1, 19'h12345, 8'h5A);
    #1 rst_in = 1'b0;
    #1 chk_zero("rst_async");
    repeat (3) begin
      @(posedge pix_clk);
      #1;
      chk_zero("rst_hold");
    end
    rst_in = 1'b1;
    step();
    chk("rel_ready", wr.ready, 1);
    chk("rel_level", fifo_level, 0);
    set_wr(1'b0, '0, '0);
    foreach (vt[i]) begin
      disp_en = vt[i].en;
      pos_x = vt[i].x;
      pos_y = vt[i].y;
      step();
      chk("vec_addr", mem_addr, vt[i].addr);
      chk("vec_we", mem_we, 0);
      disp_en = 1'b0;
      step();
      step();
      chk("vec_pix", pixel_data, vt[i].pix);
      chk("vec_pv", pixel_valid, vt[i].pv);
    end
    disp_en = 1'b1;
    pos_x = 12'd10;
    pos_y = 12'd0;
    for (int i = 0; i < 3; i++) begin
      set_wr(1'b1, AW'(100 + i), DW'(8'h10 + i));
      step();
      chk("prio_we", mem_we, 0);
    end
    chk("prio_level", fifo_level, 3);
    set_wr(1'b0, '0, '0);
    disp_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("drain_we", mem_we, 1);
      chk("drain_addr", mem_addr, 100 + i);
      chk("drain_data", mem_wdata, 32'h10 + i);
      chk("drain_level", fifo_level, 2 - i);
    end
    step();
    chk("drain_done_we", mem_we, 0);
    disp_en = 1'b1;
    pos_x = 12'd100;
    step();
    disp_en = 1'b0;
    step();
    step();
    chk("readback_pix", pixel_data, 32'h10);
    disp_en = 1'b1;
    pos_x = 12'd20;
    pos_y = 12'd1;
    for (int i = 0; i < 8; i++) begin
      set_wr(1'b1, AW'(200 + i), DW'(8'h40 + i));
      step();
    end
    chk("full_ready", wr.ready, 0);
    chk("full_level", fifo_level, 8);
    set_wr(1'b1, 19'd300, 8'h99);
    step();
    step();
    chk("full_hold_level", fifo_level, 8);
    chk("full_hold_we", mem_we, 0);
    disp_en = 1'b0;
    step();
    chk("pop1_level", fifo_level, 7);
    chk("pop1_ready", wr.ready, 1);
    chk("pop1_addr", mem_addr, 200);
    step();
    chk("ninth_level", fifo_level, 7);
    chk("pop2_addr", mem_addr, 201);
    set_wr(1'b0, '0, '0);
    for (int i = 0; i < 7; i++) begin
      step();
      chk("tail_addr", mem_addr, (i < 6) ? 202 + i : 300);
    end
    chk("ninth_data", mem_wdata, 32'h99);
    step();
    chk("full_empty_level", fifo_level, 0);
    chk("full_empty_we", mem_we, 0);
    disp_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_wr(1'b1, AW'(400 + i), DW'(8'h60 + i));
      step();
    end
    set_wr(1'b0, '0, '0);
    disp_en = 1'b0;
    step();
    chk("pre_rst_level", fifo_level, 5);
    chk("pre_rst_we", mem_we, 1);
    rst_in = 1'b0;
    #1;
    chk("mid_rst_we_now", mem_we, 0);
    chk("mid_rst_level_now", fifo_level, 0);
    model_reset();
    @(posedge pix_clk);
    #1;
    chk_zero("mid_rst");
    rst_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("no_stale_we", mem_we, 0);
    end
    chk("post_rst_level", fifo_level, 0);
    for (int s = 0; s < 120; s++) begin
      alen = $urandom_range(1, 40);
      blen = $urandom_range(0, 15);
      bx = $urandom_range(0, 630);
      by = ($urandom_range(0, 7) == 0) ? 480 : $urandom_range(0, 4);
      for (int i = 0; i < alen + blen; i++) begin
        disp_en = i < alen;
        pos_x = 12'(bx + i);
        pos_y = 12'(by);
        set_wr($urandom_range(0, 2) != 0, AW'($urandom_range(0, 3199)), DW'($urandom));
        step();
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
